// File: rtl/lru_tracker.sv
// -----------------------------------------------------------------------------
// lru_tracker
//   True-LRU replacement tracker for a set-associative cache. Each set keeps an
//   age permutation (0 = MRU, WAYS-1 = LRU) and a per-way valid bit. Accesses
//   promote a way to MRU and mark it valid. Invalidates demote a way to LRU and
//   clear its valid bit. Victim queries return a registered way one cycle later.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   acc_valid_i      access strobe (acc_set_i, acc_way_i)
//   inv_valid_i      invalidate strobe (inv_set_i, inv_way_i)
//   vic_req_i        victim query strobe (vic_set_i)
//   vic_valid_o      one-cycle pulse carrying a query result
//   vic_way_o        chosen victim way (held while vic_valid_o is low)
//   vic_was_valid_o  chosen way holds valid data and must be evicted
// -----------------------------------------------------------------------------
module lru_tracker #(
  parameter int SETS  = 1024,
  parameter int WAYS  = 4,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             acc_valid_i,
  input  logic [IDX_W-1:0] acc_set_i,
  input  logic [WAY_W-1:0] acc_way_i,
  input  logic             inv_valid_i,
  input  logic [IDX_W-1:0] inv_set_i,
  input  logic [WAY_W-1:0] inv_way_i,
  input  logic             vic_req_i,
  input  logic [IDX_W-1:0] vic_set_i,
  output logic             vic_valid_o,
  output logic [WAY_W-1:0] vic_way_o,
  output logic             vic_was_valid_o
);

  typedef logic [WAYS-1:0][WAY_W-1:0] row_t;

  localparam logic [WAY_W-1:0] AGE_LRU = WAY_W'(WAYS - 1);

  row_t             age_q [SETS];
  logic [WAYS-1:0]  vld_q [SETS];

  logic             vic_valid_q;
  logic [WAY_W-1:0] vic_way_q;
  logic             vic_was_valid_q;

  // Next-state rows for the accessed and the invalidated set.
  row_t             acc_row;
  row_t             acc_age_d;
  logic [WAY_W-1:0] acc_age;
  logic [WAYS-1:0]  acc_vld_d;
  logic             acc_apply;

  row_t             inv_row;
  row_t             inv_age_d;
  logic [WAY_W-1:0] inv_age;
  logic [WAYS-1:0]  inv_vld_d;

  // Victim selection on the pre-update state of the queried set.
  row_t             vic_row;
  logic [WAYS-1:0]  vic_vld;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] vic_way_d;
  logic             vic_was_valid_d;

  always_comb begin
    acc_row   = age_q[acc_set_i];
    acc_age   = acc_row[acc_way_i];
    acc_age_d = acc_row;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == acc_way_i) begin
        acc_age_d[w] = '0;
      end else if (acc_row[w] < acc_age) begin
        acc_age_d[w] = acc_row[w] + WAY_W'(1);
      end
    end
    acc_vld_d = vld_q[acc_set_i] | (WAYS'(1) << acc_way_i);
  end

  always_comb begin
    inv_row   = age_q[inv_set_i];
    inv_age   = inv_row[inv_way_i];
    inv_age_d = inv_row;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == inv_way_i) begin
        inv_age_d[w] = AGE_LRU;
      end else if (inv_row[w] > inv_age) begin
        inv_age_d[w] = inv_row[w] - WAY_W'(1);
      end
    end
    inv_vld_d = vld_q[inv_set_i] & ~(WAYS'(1) << inv_way_i);
  end

  // An invalidate to the same set wins; the access is dropped entirely.
  assign acc_apply = acc_valid_i && !(inv_valid_i && (inv_set_i == acc_set_i));

  always_comb begin
    vic_row         = age_q[vic_set_i];
    vic_vld         = vld_q[vic_set_i];
    lru_way         = '0;
    vic_way_d       = '0;
    vic_was_valid_d = 1'b1;
    for (int w = 0; w < WAYS; w++) begin
      if (vic_row[w] == AGE_LRU) begin
        lru_way = WAY_W'(w);
      end
    end
    // Scan downward so the lowest-index invalid way is the last one written.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vic_vld[w]) begin
        vic_way_d       = WAY_W'(w);
        vic_was_valid_d = 1'b0;
      end
    end
    if (vic_was_valid_d) begin
      vic_way_d = lru_way;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
        vld_q[s] <= '0;
      end
      vic_valid_q     <= 1'b0;
      vic_way_q       <= '0;
      vic_was_valid_q <= 1'b0;
    end else begin
      if (acc_apply) begin
        age_q[acc_set_i] <= acc_age_d;
        vld_q[acc_set_i] <= acc_vld_d;
      end
      if (inv_valid_i) begin
        age_q[inv_set_i] <= inv_age_d;
        vld_q[inv_set_i] <= inv_vld_d;
      end
      vic_valid_q <= vic_req_i;
      if (vic_req_i) begin
        vic_way_q       <= vic_way_d;
        vic_was_valid_q <= vic_was_valid_d;
      end
    end
  end

  assign vic_valid_o     = vic_valid_q;
  assign vic_way_o       = vic_way_q;
  assign vic_was_valid_o = vic_was_valid_q;

endmodule
